// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Parametrised pipeline stage register carrying an opaque DATA_W payload
//   with a valid/ready handshake, flush (bubble insert) and a saturating
//   stall counter. SKID=1 adds a second entry so in_ready comes from a flop.
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload
//   flush                 drop everything held and presented this cycle
//   stall_cnt             cycles with out_valid & ~out_ready (saturating)
module pipe_stage_reg #(
  parameter int DATA_W          = 32,
  parameter int SKID            = 0,
  parameter int CLEAR_ON_BUBBLE = 1,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              in_xfer, out_xfer;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] bubble;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign out_data = main_q;

  // Value the main register takes when its entry empties.
  assign bubble = (CLEAR_ON_BUBBLE != 0) ? '0 : main_q;

  if (SKID == 0) begin : g_single
    logic vld_q, vld_d;

    // Gated with rst_n so nothing is accepted during the reset cycle.
    assign in_ready  = rst_n & (out_ready | ~vld_q);
    assign out_valid = vld_q;

    always_comb begin
      vld_d  = vld_q;
      main_d = main_q;
      if (flush) begin
        vld_d  = 1'b0;
        main_d = bubble;
      end else if (in_xfer) begin
        vld_d  = 1'b1;
        main_d = in_data;
      end else if (out_xfer) begin
        vld_d  = 1'b0;
        main_d = bubble;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        main_q <= '0;
      end else begin
        vld_q  <= vld_d;
        main_q <= main_d;
      end
    end
  end else begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
    state_e            state_q, state_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              rdy_q;

    // rdy_q resets to 1 so the stage is ready in the first post-reset cycle.
    assign in_ready  = rst_n & rdy_q;
    assign out_valid = (state_q != EMPTY);

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
        main_d  = bubble;
        skid_d  = '0;
      end else begin
        case (state_q)
          EMPTY: if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data;
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              main_d = in_data;
            end else if (in_xfer) begin
              state_d = TWO;
              skid_d  = in_data;
            end else if (out_xfer) begin
              state_d = EMPTY;
              main_d  = bubble;
            end
          end
          TWO: if (out_xfer) begin
            // main always holds the older entry; skid moves up behind it.
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        rdy_q   <= (state_d != TWO);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && !flush && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, flush;
  logic [31:0] in_data;

  logic        inr [N];
  logic        ov  [N];
  logic [31:0] od  [N];
  logic [15:0] sc  [N];
  logic [2:0]  sc2;

  // 0: SKID=0, 1: SKID=1, 2: SKID=0 with 3-bit counter
  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CLEAR_ON_BUBBLE(1), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inr[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .flush(flush), .stall_cnt(sc[0]));
  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CLEAR_ON_BUBBLE(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inr[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .flush(flush), .stall_cnt(sc[1]));
  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CLEAR_ON_BUBBLE(1), .CNT_W(3)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inr[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .flush(flush), .stall_cnt(sc2));
  assign sc[2] = {13'd0, sc2};

  // reference model: each stage is a bounded FIFO of payloads
  logic [31:0] mq  [N][$];
  int          cap [N] = '{1, 2, 1};
  int          cmax[N] = '{65535, 65535, 7};
  int          cnt [N];
  int          n_vec, n_err;
  bit          armed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_rdy(int k);
    if (!rst_n) return 1'b0;
    if (cap[k] == 1) return out_ready || (mq[k].size() == 0);
    return mq[k].size() < 2;
  endfunction

  // One clock: inputs are already driven; check pre-edge outputs, advance model, clock.
  task automatic cycle();
    bit rdy;
    #1;
    for (int k = 0; k < N; k++) begin
      if (armed) begin
        chk($sformatf("in_ready[%0d]", k), {31'd0, inr[k]}, {31'd0, m_rdy(k)});
        chk($sformatf("out_valid[%0d]", k), {31'd0, ov[k]}, {31'd0, mq[k].size() > 0});
        chk($sformatf("out_data[%0d]", k), od[k], (mq[k].size() > 0) ? mq[k][0] : 32'd0);
        chk($sformatf("stall_cnt[%0d]", k), {16'd0, sc[k]}, cnt[k]);
      end
      rdy = m_rdy(k);
      if (!rst_n) begin
        mq[k].delete();
        cnt[k] = 0;
      end else begin
        if (mq[k].size() > 0 && !out_ready && !flush && cnt[k] < cmax[k]) cnt[k]++;
        if (mq[k].size() > 0 && out_ready) void'(mq[k].pop_front());
        if (in_valid && rdy && !flush) mq[k].push_back(in_data);
        if (flush) mq[k].delete();
      end
    end
    @(posedge clk);
    #1;
    armed = 1'b1;
  endtask

  task automatic drv(input bit r, input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
    rst_n = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    cycle();
  endtask

  initial begin
    n_vec = 0; n_err = 0; armed = 1'b0;
    for (int k = 0; k < N; k++) cnt[k] = 0;

    // reset with garbage presented
    drv(0, 1, 32'hDEADBEEF, 1, 0);
    drv(0, 1, 32'hDEADBEEF, 1, 0);
    drv(1, 0, 32'h0, 1, 0);

    // back-to-back stream
    for (int i = 1; i <= 8; i++) drv(1, 1, i, 1, 0);
    drv(1, 0, 0, 1, 0);
    drv(1, 0, 0, 1, 0);

    // stall: 0xA5 held, then 0xA6 offered while blocked
    drv(1, 1, 32'hA5, 0, 0);
    for (int i = 0; i < 5; i++) drv(1, 1, 32'hA6, 0, 0);
    chk("stall_cnt5_d0", {16'd0, sc[0]}, 32'd5);
    for (int i = 0; i < 3; i++) drv(1, 0, 0, 1, 0);

    // flush with skid stage full
    drv(0, 0, 0, 1, 0);
    drv(1, 1, 32'h11, 0, 0);
    drv(1, 1, 32'h22, 0, 0);
    drv(1, 1, 32'h33, 0, 1);
    chk("flush_out_valid_d1", {31'd0, ov[1]}, 32'd0);
    chk("flush_out_data_d1", od[1], 32'd0);
    for (int i = 0; i < 2; i++) drv(1, 0, 0, 1, 0);

    // saturation of the 3-bit counter
    drv(0, 0, 0, 1, 0);
    drv(1, 1, 32'h5A, 0, 0);
    for (int i = 0; i < 10; i++) drv(1, 0, 0, 0, 0);
    chk("sat_cnt_d2", {29'd0, sc2}, 32'd7);
    drv(1, 0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      drv(($urandom_range(99) != 0), ($urandom_range(9) < 7), $urandom,
          ($urandom_range(9) < 6), ($urandom_range(19) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
